ext_align_unit: RTL and testbench

Parametrised, pipelined immediate/load-data extension stage for the MIPS datapath, the successor to the single-cycle 16→32 sign/zero extender. It supports immediate zero/sign extension, LUI placement, and byte/halfword/word load-data lane selection with sign or zero extension. Misaligned accesses are flagged. A valid/ready handshake with a 2-entry skid buffer lets it sit between the memory-read stage and writeback, or between decode and execute, without combinational ready paths.

---
 rtl/ext_pkg.sv | 32 +++
 rtl/ext_core.sv | 89 ++++++++
 rtl/ext_align_unit.sv | 96 +++++++++
 tb/tb_ext_align_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared types for the extension/alignment stage: operation codes and the
// request/response records passed between the handshake shell and ext_core.
package ext_pkg;

    // Records are sized for the widest supported datapath; narrower
    // instances use the low bits and leave the rest at zero.
    localparam int XLEN_MAX = 64;
    localparam int OFF_MAX  = 3;

    typedef enum logic [2:0] {
        EXT_ZEXT = 3'd0,
        EXT_SEXT = 3'd1,
        EXT_LUI  = 3'd2,
        EXT_LB   = 3'd3,
        EXT_LBU  = 3'd4,
        EXT_LH   = 3'd5,
        EXT_LHU  = 3'd6,
        EXT_LW   = 3'd7
    } ext_mode_e;

    typedef struct packed {
        ext_mode_e               mode;
        logic [OFF_MAX-1:0]      off;
        logic [XLEN_MAX-1:0]     data;
    } ext_req_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0]     result;
        logic                    align_err;
    } ext_rsp_t;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate / load-data extension: maps one request record to
// its extended result and misalignment flag.
module ext_core
    import ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  ext_req_t req,
    output ext_rsp_t rsp
);

    logic [XLEN-1:0]  data;
    logic [OFF_W-1:0] off;
    logic [7:0]       lanes [XLEN/8];

    logic [XLEN-1:0]  immZ;
    logic [XLEN-1:0]  immS;
    logic [XLEN-1:0]  luiVal;
    logic [7:0]       byteSel;
    logic [15:0]      halfSel;
    logic [31:0]      wordSel;
    logic [XLEN-1:0]  result;
    logic             alignErr;

    assign data = req.data[XLEN-1:0];
    assign off  = req.off[OFF_W-1:0];

    for (genvar gi = 0; gi < XLEN / 8; gi++) begin : gLane
        assign lanes[gi] = data[8*gi +: 8];
    end

    // Shifting the immediate to the top and back clears or replicates the
    // bits above IMM_W without a zero-width replication when IMM_W == XLEN.
    assign immZ = (data << (XLEN - IMM_W)) >> (XLEN - IMM_W);
    assign immS = $signed(data << (XLEN - IMM_W)) >>> (XLEN - IMM_W);

    // The LUI image is formed in 32 bits, then sign-extended for 64-bit cores.
    assign luiVal = XLEN'($signed(32'(immZ) << 16));

    // Upper-lane indices wrap; they only matter for offsets that are aligned.
    assign byteSel = lanes[off];
    assign halfSel = {lanes[OFF_W'(off + 1)], lanes[off]};
    assign wordSel = {lanes[OFF_W'(off + 3)], lanes[OFF_W'(off + 2)],
                      lanes[OFF_W'(off + 1)], lanes[off]};

    always_comb begin
        result   = '0;
        alignErr = 1'b0;
        case (req.mode)
            EXT_ZEXT: result = immZ;
            EXT_SEXT: result = immS;
            EXT_LUI:  result = luiVal;
            EXT_LB:   result = XLEN'($signed(byteSel));
            EXT_LBU:  result = XLEN'(byteSel);
            EXT_LH: begin
                alignErr = off[0];
                result   = XLEN'($signed(halfSel));
            end
            EXT_LHU: begin
                alignErr = off[0];
                result   = XLEN'(halfSel);
            end
            EXT_LW: begin
                alignErr = (off[1:0] != 2'b00);
                result   = XLEN'($signed(wordSel));
            end
            default: result = '0;
        endcase
        if (alignErr) begin
            result = '0;
        end
    end

    assign rsp.result    = XLEN_MAX'(result);
    assign rsp.align_err = alignErr;

    if (XLEN < XLEN_MAX) begin : gDataPad
        logic unusedData;
        assign unusedData = ^req.data[XLEN_MAX-1:XLEN];
    end

    if (OFF_W < OFF_MAX) begin : gOffPad
        logic unusedOff;
        assign unusedOff = ^req.off[OFF_MAX-1:OFF_W];
    end

endmodule

// File: rtl/ext_align_unit.sv
// Pipelined extension stage: ext_core behind a valid/ready shell with an
// output register and one skid register, so InReady never depends on OutReady.
module ext_align_unit
    import ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ExtMode,
    input  logic [OFF_W-1:0] ByteOff,
    input  logic [XLEN-1:0]  DataIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ExtResult,
    output logic             AlignErr
);

    ext_req_t        coreReq;
    ext_rsp_t        coreRsp;
    logic [XLEN-1:0] coreResult;

    logic            outValidReg;
    logic [XLEN-1:0] outResultReg;
    logic            outErrReg;
    logic            skidValidReg;
    logic [XLEN-1:0] skidResultReg;
    logic            skidErrReg;

    logic            accept;
    logic            drain;

    assign coreReq.mode = ext_mode_e'(ExtMode);
    assign coreReq.off  = OFF_MAX'(ByteOff);
    assign coreReq.data = XLEN_MAX'(DataIn);

    ext_core #(
        .XLEN  (XLEN),
        .IMM_W (IMM_W),
        .OFF_W (OFF_W)
    ) uCore (
        .req (coreReq),
        .rsp (coreRsp)
    );

    assign coreResult = coreRsp.result[XLEN-1:0];

    if (XLEN < XLEN_MAX) begin : gRspPad
        logic unusedRsp;
        assign unusedRsp = ^coreRsp.result[XLEN_MAX-1:XLEN];
    end

    assign accept = InValid && !skidValidReg;
    assign drain  = outValidReg && OutReady;

    // The skid entry is only ever filled while the output register is
    // occupied, so a full skid always implies a valid output.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            outValidReg   <= 1'b0;
            outResultReg  <= '0;
            outErrReg     <= 1'b0;
            skidValidReg  <= 1'b0;
            skidResultReg <= '0;
            skidErrReg    <= 1'b0;
        end else if (skidValidReg) begin
            if (drain) begin
                outResultReg <= skidResultReg;
                outErrReg    <= skidErrReg;
                skidValidReg <= 1'b0;
            end
        end else if (accept) begin
            if (!outValidReg || OutReady) begin
                outValidReg  <= 1'b1;
                outResultReg <= coreResult;
                outErrReg    <= coreRsp.align_err;
            end else begin
                skidValidReg  <= 1'b1;
                skidResultReg <= coreResult;
                skidErrReg    <= coreRsp.align_err;
            end
        end else if (drain) begin
            outValidReg <= 1'b0;
        end
    end

    assign InReady   = !skidValidReg;
    assign OutValid  = outValidReg;
    assign ExtResult = outResultReg;
    assign AlignErr  = outErrReg;

endmodule

// File: tb/tb_ext_align_unit.sv
// Randomised and directed scoreboard bench for ext_align_unit (32- and 64-bit).
module tb_ext_align_unit;

    logic        CLK = 1'b0;
    logic        Reset;

    logic        InValid, InReady, OutValid, OutReady, AlignErr;
    logic [2:0]  ExtMode;
    logic [1:0]  ByteOff;
    logic [31:0] DataIn, ExtResult;

    logic        InValid64, InReady64, OutValid64, OutReady64, AlignErr64;
    logic [2:0]  ExtMode64;
    logic [2:0]  ByteOff64;
    logic [63:0] DataIn64, ExtResult64;

    int checks = 0;
    int errors = 0;

    logic [64:0] expQ   [$];
    logic [64:0] expQ64 [$];

    always #5 CLK = ~CLK;

    ext_align_unit #(.XLEN(32), .IMM_W(16)) dut32 (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .ExtMode(ExtMode), .ByteOff(ByteOff), .DataIn(DataIn),
        .OutValid(OutValid), .OutReady(OutReady),
        .ExtResult(ExtResult), .AlignErr(AlignErr)
    );

    ext_align_unit #(.XLEN(64), .IMM_W(16)) dut64 (
        .CLK(CLK), .Reset(Reset), .InValid(InValid64), .InReady(InReady64),
        .ExtMode(ExtMode64), .ByteOff(ByteOff64), .DataIn(DataIn64),
        .OutValid(OutValid64), .OutReady(OutReady64),
        .ExtResult(ExtResult64), .AlignErr(AlignErr64)
    );

    // Reference: {align_err, result} from the operation rules in plain arithmetic.
    function automatic logic [64:0] model(input int xlen, input int immW,
                                          input logic [2:0] mode, input int off,
                                          input logic [63:0] data);
        logic [63:0] immMask, imm, v, r, xmask;
        logic        err;
        immMask = (64'd1 << immW) - 64'd1;
        imm     = data & immMask;
        xmask   = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v       = data >> (8 * off);
        err     = 1'b0;
        r       = 64'd0;
        case (mode)
            3'd0: r = imm;
            3'd1: r = imm[immW-1] ? (imm | ~immMask) : imm;
            3'd2: begin
                r = (imm << 16) & 64'hFFFF_FFFF;
                if (r[31]) r = r | 64'hFFFF_FFFF_0000_0000;
            end
            3'd3: r = v[7]  ? ((v & 64'hFF) | ~64'hFF) : (v & 64'hFF);
            3'd4: r = v & 64'hFF;
            3'd5: begin
                err = (off % 2) != 0;
                r = v[15] ? ((v & 64'hFFFF) | ~64'hFFFF) : (v & 64'hFFFF);
            end
            3'd6: begin
                err = (off % 2) != 0;
                r = v & 64'hFFFF;
            end
            default: begin
                err = (off % 4) != 0;
                r = v[31] ? ((v & 64'hFFFF_FFFF) | ~64'hFFFF_FFFF) : (v & 64'hFFFF_FFFF);
            end
        endcase
        if (err) r = 64'd0;
        return {err, r & xmask};
    endfunction

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // 32-bit monitor: pop/compare on every consumed result, push on every accept.
    logic        stall32;
    logic [32:0] held32;
    always @(negedge CLK) begin
        if (Reset) begin
            expQ.delete();
            stall32 = 1'b0;
        end else begin
            if (stall32)
                check("hold32", {31'd0, OutValid, AlignErr, ExtResult}, {31'd0, 1'b1, held32});
            if (OutValid && OutReady) begin
                if (expQ.size() == 0) begin
                    check("unexpected32", {64'd0, OutValid}, 65'd0);
                end else begin
                    logic [64:0] e;
                    e = expQ.pop_front();
                    check("sb32", {AlignErr, 32'd0, ExtResult}, e);
                    $display("txn32 res=%h err=%b", ExtResult, AlignErr);
                end
            end
            if (InValid && InReady)
                expQ.push_back(model(32, 16, ExtMode, int'(ByteOff), {32'd0, DataIn}));
            stall32 = OutValid && !OutReady;
            held32  = {AlignErr, ExtResult};
        end
    end

    always @(negedge CLK) begin
        if (Reset) begin
            expQ64.delete();
        end else begin
            if (OutValid64 && OutReady64) begin
                if (expQ64.size() == 0) begin
                    check("unexpected64", {64'd0, OutValid64}, 65'd0);
                end else begin
                    logic [64:0] e;
                    e = expQ64.pop_front();
                    check("sb64", {AlignErr64, ExtResult64}, e);
                    $display("txn64 res=%h err=%b", ExtResult64, AlignErr64);
                end
            end
            if (InValid64 && InReady64)
                expQ64.push_back(model(64, 16, ExtMode64, int'(ByteOff64), DataIn64));
        end
    end

    // Present one request and hold it until accepted (bounded wait).
    task automatic issue(input logic [2:0] m, input logic [1:0] o, input logic [31:0] d);
        int n;
        ExtMode = m; ByteOff = o; DataIn = d; InValid = 1'b1;
        n = 0;
        while (!InReady && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n == 50) check("accept_timeout", {64'd0, InReady}, 65'd1);
        @(posedge CLK); #1;
        InValid = 1'b0;
    endtask

    task automatic sendChk(input string name, input logic [2:0] m, input logic [1:0] o,
                           input logic [31:0] d, input logic [31:0] expRes, input logic expErr);
        OutReady = 1'b1;
        issue(m, o, d);
        check({name, "_valid"}, {64'd0, OutValid}, 65'd1);
        check(name, {AlignErr, 32'd0, ExtResult}, {expErr, 32'd0, expRes});
    endtask

    initial begin
        Reset = 1'b1;
        InValid = 0; ExtMode = 0; ByteOff = 0; DataIn = 0; OutReady = 0;
        InValid64 = 0; ExtMode64 = 0; ByteOff64 = 0; DataIn64 = 0; OutReady64 = 1;
        #2;
        check("rst_outvalid", {64'd0, OutValid}, 65'd0);
        check("rst_inready",  {64'd0, InReady},  65'd1);
        check("rst_result",   {AlignErr, 32'd0, ExtResult}, 65'd0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(posedge CLK); #1;

        // 64-bit datapath: LUI sign extension and upper-word load.
        ExtMode64 = 3'd2; ByteOff64 = 3'd0; DataIn64 = 64'h8000; InValid64 = 1'b1;
        @(posedge CLK); #1;
        check("lui64", {AlignErr64, ExtResult64}, {1'b0, 64'hFFFF_FFFF_8000_0000});
        ExtMode64 = 3'd7; ByteOff64 = 3'd4; DataIn64 = 64'h89AB_CDEF_0123_4567;
        @(posedge CLK); #1;
        check("lw64_off4", {AlignErr64, ExtResult64}, {1'b0, 64'hFFFF_FFFF_89AB_CDEF});
        for (int i = 0; i < 30; i++) begin
            ExtMode64 = 3'($urandom_range(0, 7));
            ByteOff64 = 3'($urandom_range(0, 7));
            DataIn64  = {$urandom, $urandom};
            @(posedge CLK); #1;
        end
        InValid64 = 1'b0;

        // Directed single requests with latency-1 output check.
        sendChk("sext",    3'd1, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
        sendChk("zext",    3'd0, 2'd0, 32'h0000_8001, 32'h0000_8001, 1'b0);
        sendChk("lui",     3'd2, 2'd0, 32'h0000_1234, 32'h1234_0000, 1'b0);
        sendChk("lb3",     3'd3, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0);
        sendChk("lbu1",    3'd4, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
        sendChk("lh2",     3'd5, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
        sendChk("lhu0",    3'd6, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0);
        sendChk("lh1_mis", 3'd5, 2'd1, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        sendChk("lw2_mis", 3'd7, 2'd2, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
        sendChk("lw0",     3'd7, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0);
        @(posedge CLK); #1;

        // Backpressure: A to output, B to skid, C refused until the first drain.
        OutReady = 1'b0;
        ExtMode = 3'd3; ByteOff = 2'd3; DataIn = 32'h80FF_7F01; InValid = 1'b1;
        @(posedge CLK); #1;
        check("bp_a_out", {AlignErr, 32'd0, ExtResult}, {33'd0, 32'hFFFF_FF80});
        check("bp_ready_a", {64'd0, InReady}, 65'd1);
        ExtMode = 3'd4; ByteOff = 2'd1;
        @(posedge CLK); #1;
        check("bp_ready_full", {64'd0, InReady}, 65'd0);
        ExtMode = 3'd6; ByteOff = 2'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("bp_ready_still", {64'd0, InReady}, 65'd0);
        check("bp_a_held", {AlignErr, 32'd0, ExtResult}, {33'd0, 32'hFFFF_FF80});
        OutReady = 1'b1;
        @(posedge CLK); #1;
        check("bp_ready_back", {64'd0, InReady}, 65'd1);
        check("bp_b_out", {AlignErr, 32'd0, ExtResult}, {33'd0, 32'h0000_007F});
        @(posedge CLK); #1;
        InValid = 1'b0;
        check("bp_c_out", {AlignErr, 32'd0, ExtResult}, {33'd0, 32'h0000_7F01});
        check("bp_c_valid", {64'd0, OutValid}, 65'd1);
        @(posedge CLK); #1;
        check("bp_empty", {64'd0, OutValid}, 65'd0);

        // Streaming: one random request per cycle, no bubbles.
        OutReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("stream_ready", {64'd0, InReady}, 65'd1);
            ExtMode = 3'($urandom_range(0, 7));
            ByteOff = 2'($urandom_range(0, 3));
            DataIn  = $urandom;
            InValid = 1'b1;
            @(posedge CLK); #1;
            check("stream_valid", {64'd0, OutValid}, 65'd1);
        end
        InValid = 1'b0;
        @(posedge CLK); #1;

        // Reset with both entries occupied.
        OutReady = 1'b0;
        ExtMode = 3'd1; ByteOff = 2'd0; DataIn = $urandom; InValid = 1'b1;
        @(posedge CLK); #1;
        DataIn = $urandom;
        @(posedge CLK); #1;
        InValid = 1'b0;
        check("mid_full", {64'd0, InReady}, 65'd0);
        Reset = 1'b1;
        #1;
        check("mid_rst_valid", {64'd0, OutValid}, 65'd0);
        check("mid_rst_ready", {64'd0, InReady}, 65'd1);
        @(posedge CLK); #1;
        Reset = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("no_stale", {64'd0, OutValid}, 65'd0);
        end

        begin
            int n;
            n = 0;
            while ((expQ.size() != 0 || expQ64.size() != 0) && n < 20) begin
                @(posedge CLK); #1;
                n++;
            end
        end
        check("queue32_empty", 65'(expQ.size()), 65'd0);
        check("queue64_empty", 65'(expQ64.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
